// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Brief    : Shared constants and types for the two-port SRAM arbiter/controller
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

  // memCtl bit positions; every strobe is active-low
  localparam int CTL_CE_N = 0;
  localparam int CTL_OE_N = 1;
  localparam int CTL_WE_N = 2;
  localparam int CTL_LB_N = 3;
  localparam int CTL_UB_N = 4;

  localparam logic [4:0] CTL_IDLE = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } sram_state_e;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } sram_req_t;

endpackage
`default_nettype wire

// File: rtl/sram_arb.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb
// Brief    : Two-requester grant logic; a tie goes to the requester not last served
// Revision : 1.0 - initial release
// ============================================================================
module sram_arb (
  input  logic [1:0] valid,
  input  logic       last_served,
  output logic [1:0] grant
);

  // Holding last_served at 1 turns this into fixed priority for requester 0
  always_comb begin
    grant = 2'b00;
    if (valid[0] && (!valid[1] || last_served)) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_arb_ctrl
// Brief    : Two-port arbiter and async SRAM access sequencer (SETUP/STROBE/HOLD).
//            Define SRAM_ARB_RR_EN for round-robin ties; otherwise port 0 wins.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arb_ctrl
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [15:0] req0_addr,
  input  logic [15:0] req0_wdata,
  input  logic [1:0]  req0_be,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [15:0] req1_addr,
  input  logic [15:0] req1_wdata,
  input  logic [1:0]  req1_be,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp_rdata,
  output logic [4:0]  memCtl,
  output logic [15:0] memAddr,
  output logic [15:0] memDataOut,
  output logic        memDataOe,
  input  logic [15:0] memDataIn
);

  localparam logic [3:0] C_STROBE_LAST = 4'(WAIT_CYCLES - 1);

  sram_state_e r_state;
  sram_req_t   r_req;
  logic [3:0]  r_cnt;
  logic        r_sel;
  logic [15:0] r_rdata;

  logic [1:0]  w_grant;
  logic        w_last;
  logic        w_idle;
  logic        w_strobe;
  logic        w_accept;
  sram_req_t   w_req0;
  sram_req_t   w_req1;
  logic [4:0]  w_ctl;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_strobe = (r_state == ST_STROBE);
  assign w_accept = w_idle && (w_grant != 2'b00);

  assign w_req0 = '{write: req0_write, addr: req0_addr, wdata: req0_wdata, be: req0_be};
  assign w_req1 = '{write: req1_write, addr: req1_addr, wdata: req1_wdata, be: req1_be};

  sram_arb u_arb (
    .valid       ({req1_valid, req0_valid}),
    .last_served (w_last),
    .grant       (w_grant)
  );

`ifdef SRAM_ARB_RR_EN
  logic r_last;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_grant[1];
    end
  end

  assign w_last = r_last;
`else
  assign w_last = 1'b1;
`endif

  // Reset is folded into ready so no handshake can be seen while held in reset
  assign req0_ready = RESET && w_idle && w_grant[0];
  assign req1_ready = RESET && w_idle && w_grant[1];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SETUP;
            r_sel   <= w_grant[1];
            r_req   <= w_grant[1] ? w_req1 : w_req0;
          end
        end
        ST_SETUP: begin
          r_state <= ST_STROBE;
          r_cnt   <= '0;
        end
        ST_STROBE: begin
          if (r_cnt == C_STROBE_LAST) begin
            r_state <= ST_HOLD;
            if (!r_req.write) begin
              r_rdata <= memDataIn;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_HOLD: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Reads always fetch the full word; writes drive only the enabled byte lanes
  always_comb begin
    w_ctl = CTL_IDLE;
    if (!w_idle) begin
      w_ctl[CTL_CE_N] = 1'b0;
      if (r_req.write) begin
        w_ctl[CTL_WE_N] = !w_strobe;
        w_ctl[CTL_LB_N] = !r_req.be[0];
        w_ctl[CTL_UB_N] = !r_req.be[1];
      end else begin
        w_ctl[CTL_OE_N] = !w_strobe;
        w_ctl[CTL_LB_N] = 1'b0;
        w_ctl[CTL_UB_N] = 1'b0;
      end
    end
  end

  assign memCtl     = w_ctl;
  assign memAddr    = r_req.addr;
  assign memDataOut = r_req.wdata;
  assign memDataOe  = !w_idle && r_req.write;

  assign rsp0_valid = (r_state == ST_HOLD) && !r_sel;
  assign rsp1_valid = (r_state == ST_HOLD) && r_sel;
  assign rsp_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arb_ctrl
// Brief    : Random two-port traffic on three controllers (W=2, 1, 15) against
//            a per-access timeline model; SRAM_ARB_RR_EN selects the tie rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arb_ctrl;

  localparam int ND = 3;

  function automatic int wv(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  logic        rq_valid [ND][2];
  logic        rq_write [ND][2];
  logic [15:0] rq_addr  [ND][2];
  logic [15:0] rq_wdata [ND][2];
  logic [1:0]  rq_be    [ND][2];
  logic        rq_ready [ND][2];
  logic        rsp_v    [ND][2];
  logic [15:0] rdata    [ND];
  logic [4:0]  ctl      [ND];
  logic [15:0] maddr    [ND];
  logic [15:0] mdout    [ND];
  logic [15:0] mdin     [ND];
  logic        moe      [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    sram_arb_ctrl #(.WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))) u_dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .req0_valid (rq_valid[g][0]),
      .req0_write (rq_write[g][0]),
      .req0_addr  (rq_addr[g][0]),
      .req0_wdata (rq_wdata[g][0]),
      .req0_be    (rq_be[g][0]),
      .req0_ready (rq_ready[g][0]),
      .req1_valid (rq_valid[g][1]),
      .req1_write (rq_write[g][1]),
      .req1_addr  (rq_addr[g][1]),
      .req1_wdata (rq_wdata[g][1]),
      .req1_be    (rq_be[g][1]),
      .req1_ready (rq_ready[g][1]),
      .rsp0_valid (rsp_v[g][0]),
      .rsp1_valid (rsp_v[g][1]),
      .rsp_rdata  (rdata[g]),
      .memCtl     (ctl[g]),
      .memAddr    (maddr[g]),
      .memDataOut (mdout[g]),
      .memDataOe  (moe[g]),
      .memDataIn  (mdin[g])
    );
  end

  // Model: each access is a timeline of offsets 1..W+2 after its accept edge
  bit          m_busy  [ND];
  int          m_k     [ND];
  bit          m_sel   [ND];
  bit          m_write [ND];
  logic [15:0] m_addr  [ND];
  logic [15:0] m_wdata [ND];
  logic [1:0]  m_be    [ND];
  logic [15:0] m_rdata [ND];
  logic [15:0] m_cap   [ND];
  bit          m_last  [ND];
  bit          m_acc   [ND][2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_busy[d]   = 1'b0;
      m_k[d]      = 0;
      m_last[d]   = 1'b1;
      m_rdata[d]  = 16'h0;
      m_acc[d][0] = 1'b0;
      m_acc[d][1] = 1'b0;
    end
  endtask

  task automatic sample();
    for (int d = 0; d < ND; d++) begin
      int         w;
      bit         strobe;
      bit         hold;
      bit         g0;
      bit         g1;
      bit         pick0;
      logic [4:0] e;
      w = wv(d);
      check($sformatf("d%0d oe_overlap", d), 16'(moe[d] & ~ctl[d][1]), 16'h0);
      if (!RESET) begin
        m_acc[d][0] = 1'b0;
        m_acc[d][1] = 1'b0;
        check($sformatf("d%0d rst_ctl", d), 16'(ctl[d]), 16'h1f);
        check($sformatf("d%0d rst_oe", d), 16'(moe[d]), 16'h0);
        check($sformatf("d%0d rst_addr", d), maddr[d], 16'h0);
        check($sformatf("d%0d rst_ready", d), 16'({rq_ready[d][1], rq_ready[d][0]}), 16'h0);
        check($sformatf("d%0d rst_rsp", d), 16'({rsp_v[d][1], rsp_v[d][0]}), 16'h0);
        check($sformatf("d%0d rst_rdata", d), rdata[d], 16'h0);
      end else if (!m_busy[d]) begin
`ifdef SRAM_ARB_RR_EN
        pick0 = m_last[d];
`else
        pick0 = 1'b1;
`endif
        g0 = rq_valid[d][0] && (!rq_valid[d][1] || pick0);
        g1 = rq_valid[d][1] && !g0;
        m_acc[d][0] = g0;
        m_acc[d][1] = g1;
        check($sformatf("d%0d ready", d), 16'({rq_ready[d][1], rq_ready[d][0]}), 16'({g1, g0}));
        check($sformatf("d%0d idle_ctl", d), 16'(ctl[d]), 16'h1f);
        check($sformatf("d%0d idle_oe", d), 16'(moe[d]), 16'h0);
        check($sformatf("d%0d idle_rsp", d), 16'({rsp_v[d][1], rsp_v[d][0]}), 16'h0);
        check($sformatf("d%0d rdata", d), rdata[d], m_rdata[d]);
      end else begin
        m_acc[d][0] = 1'b0;
        m_acc[d][1] = 1'b0;
        strobe = (m_k[d] >= 2) && (m_k[d] <= w + 1);
        hold   = (m_k[d] == w + 2);
        e[0] = 1'b0;
        e[1] = !(!m_write[d] && strobe);
        e[2] = !(m_write[d] && strobe);
        e[3] = m_write[d] ? !m_be[d][0] : 1'b0;
        e[4] = m_write[d] ? !m_be[d][1] : 1'b0;
        check($sformatf("d%0d k%0d ctl", d, m_k[d]), 16'(ctl[d]), 16'(e));
        check($sformatf("d%0d k%0d addr", d, m_k[d]), maddr[d], m_addr[d]);
        check($sformatf("d%0d k%0d oe", d, m_k[d]), 16'(moe[d]), 16'(m_write[d]));
        if (m_write[d]) check($sformatf("d%0d k%0d dout", d, m_k[d]), mdout[d], m_wdata[d]);
        check($sformatf("d%0d k%0d busy_ready", d, m_k[d]),
              16'({rq_ready[d][1], rq_ready[d][0]}), 16'h0);
        check($sformatf("d%0d k%0d rsp", d, m_k[d]), 16'({rsp_v[d][1], rsp_v[d][0]}),
              16'({hold && m_sel[d], hold && !m_sel[d]}));
        check($sformatf("d%0d k%0d rdata", d, m_k[d]), rdata[d], m_rdata[d]);
        if (m_k[d] == w + 1) m_cap[d] = mdin[d];
      end
    end
  endtask

  task automatic advance();
    if (!RESET) return;
    for (int d = 0; d < ND; d++) begin
      int r;
      if (m_busy[d]) begin
        if (m_k[d] == wv(d) + 1 && !m_write[d]) m_rdata[d] = m_cap[d];
        if (m_k[d] == wv(d) + 2) m_busy[d] = 1'b0;
        else m_k[d] = m_k[d] + 1;
      end else if (m_acc[d][0] || m_acc[d][1]) begin
        r          = m_acc[d][1] ? 1 : 0;
        m_busy[d]  = 1'b1;
        m_k[d]     = 1;
        m_sel[d]   = (r == 1);
        m_write[d] = rq_write[d][r];
        m_addr[d]  = rq_addr[d][r];
        m_wdata[d] = rq_wdata[d][r];
        m_be[d]    = rq_be[d][r];
        m_last[d]  = (r == 1);
      end
    end
  endtask

  task automatic drive(input bit rst_now);
    for (int d = 0; d < ND; d++) begin
      for (int r = 0; r < 2; r++) begin
        if (m_acc[d][r]) rq_valid[d][r] = 1'b0;
        if (!rq_valid[d][r] && $urandom_range(0, 3) != 0) begin
          rq_valid[d][r] = 1'b1;
          rq_write[d][r] = 1'($urandom_range(0, 1));
          rq_addr[d][r]  = 16'($urandom);
          rq_wdata[d][r] = 16'($urandom);
          rq_be[d][r]    = 2'($urandom_range(0, 3));
        end
      end
      mdin[d] = 16'($urandom);
    end
    if (rst_now) begin
      RESET = 1'b0;
      model_reset();
    end else begin
      RESET = 1'b1;
    end
  endtask

  // mode 0: rare random resets; mode 1: reset once inside a W=15 write strobe
  bit strobe_rst_done = 1'b0;

  task automatic step(input int mode);
    bit rst;
    sample();
    @(posedge CLK);
    advance();
    #1;
    rst = 1'b0;
    if (RESET) begin
      if (mode == 0) begin
        rst = ($urandom_range(0, 199) == 0);
      end else if (!strobe_rst_done && m_busy[2] && m_write[2] &&
                   m_k[2] >= 2 && m_k[2] <= wv(2) + 1) begin
        rst = 1'b1;
        strobe_rst_done = 1'b1;
      end
    end
    drive(rst);
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b0;
    for (int d = 0; d < ND; d++) begin
      for (int r = 0; r < 2; r++) begin
        rq_valid[d][r] = 1'b0;
        rq_write[d][r] = 1'b0;
        rq_addr[d][r]  = 16'h0;
        rq_wdata[d][r] = 16'h0;
        rq_be[d][r]    = 2'b00;
      end
      mdin[d] = 16'h0;
    end
    model_reset();
    @(negedge CLK);
    sample();
    @(posedge CLK);
    #1;
    drive(1'b0);
    @(negedge CLK);
    repeat (3000) step(0);
    for (int i = 0; i < 400 && !strobe_rst_done; i++) step(1);
    check("d2 strobe_reset_reached", 16'(strobe_rst_done), 16'h1);
    repeat (60) step(0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
